audplay_controller: RTL and testbench
=====================================

AUDPLAY_CONTROLLER -- requirements
Module: audplay_controller

Interface
REQ-001 SHALL have parameter PRIMARY_DIV, default 26, giving clk cycles per sck half-period (one trigger tick).
REQ-002 SHALL have port clk, input, 1: sole clock.
REQ-003 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port addr, input, 4: byte address.
REQ-005 SHALL have port w_rb, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have port acc, input, `BUS_ACC_WIDTH: access size.
REQ-007 SHALL have port rdata, output, `BUS_WIDTH: registered read data.
REQ-008 SHALL have port wdata, input, `BUS_WIDTH: write data.
REQ-009 SHALL have port req, input, 1: request strobe.
REQ-010 SHALL have port resp, output, 1: response strobe, one cycle after a valid req.
REQ-011 SHALL have port fault, output, 1: combinational, req AND invalid.
REQ-012 SHALL have port sck, output, 1: serial bit clock.
REQ-013 SHALL have port ws, output, 1: word select (0 = left, 1 = right).
REQ-014 SHALL have port sd, output, 1: serial data, MSB first.

Function
REQ-015 Register map SHALL be: DR at 0 (write-only, pushes a sample); SR at 4 (read-only); CR at 8 (write-only).
REQ-016 SR SHALL be: UNDERRUN(31) sticky, FULL(30), EMPTY(29), LEVEL(20:16), FRAMES(15:0); all other bits 0.
REQ-017 CR SHALL be: EN(31), FLUSH(30) self-clearing; all other bits ignored.
REQ-018 Invalid SHALL mean any of: addr[1:0]!=0; acc!=`BUS_ACC_4B; addr>8; write to SR; read of DR or CR; DR write while FULL.
REQ-019 On valid req, resp SHALL be 1 in the next cycle; invalid req SHALL produce no resp and no state change.
REQ-020 An SR read SHALL load rdata with SR sampled in the req cycle and clear UNDERRUN in that same cycle; an underrun in the same cycle SHALL win.
REQ-021 Sample FIFO SHALL be 16 entries deep, first-in first-out; LEVEL SHALL count 0..16, FULL = (LEVEL==16), EMPTY = (LEVEL==0).
REQ-022 Trigger SHALL pulse one cycle every PRIMARY_DIV clk cycles from a free-running divider; the state machine and count SHALL advance only on trigger.
REQ-023 States SHALL be IDLE, LOW, HIGH with a 6-bit count 0..63 per state; at count==63 the transitions SHALL be IDLE->LOW, LOW->HIGH and HIGH->LOW, with count returning to 0.
REQ-024 With EN=0 the block SHALL hold IDLE with count 0; EN 1->0 SHALL force IDLE/count 0 at the next clk, mid-frame included.
REQ-025 Outputs SHALL be sck = (IDLE) OR count[0]; ws = (IDLE) OR (HIGH).
REQ-026 For LOW/HIGH with b = count[5:1], sd SHALL be channel bit (16-b) for b in 1..16 and 0 otherwise; sd SHALL be 0 in IDLE.
REQ-027 Pop SHALL occur on the trigger entering LOW; the popped word SHALL be held for the whole frame (LOW and HIGH).
REQ-028 Pop when EMPTY SHALL transmit 0 on both channels and set UNDERRUN; LEVEL SHALL stay 0.
REQ-029 Simultaneous push and pop SHALL leave LEVEL unchanged; push with pop-on-empty SHALL store the word and set LEVEL=1 and UNDERRUN.
REQ-030 FRAMES SHALL increment on every LOW entry, wrapping 0xFFFF->0.
REQ-031 FLUSH SHALL empty the FIFO in the next cycle, overriding any same-cycle push or pop.

Reset
REQ-032 On rstn=0 at a clk edge: resp=0, rdata=0, EN=0, FIFO empty, UNDERRUN=0, FRAMES=0, divider=0, state=IDLE, count=0.
REQ-033 Under reset the outputs SHALL be sck=1, ws=1, sd=0, fault=req AND invalid.

Configuration
REQ-034 With AUDPLAY_STEREO_EN defined: left = DR[15:0], right = DR[31:16].
REQ-035 Without AUDPLAY_STEREO_EN: DR[15:0] SHALL drive both channels and DR[31:16] SHALL be ignored.

Verification
REQ-036 Reset, then read SR -> rdata=0x20000000, resp one cycle later, sck=1, ws=1, sd=0.
REQ-037 Push 0xA5C3, write CR=0x80000000, PRIMARY_DIV=4 -> after 64 IDLE ticks, ws low 64 ticks; sd bits 1010010111000011 at b=1..16; FRAMES=1.
REQ-038 Push 17 words -> the 17th push asserts fault with no resp; SR LEVEL=16, FULL=1.
REQ-039 EN=1 with empty FIFO -> sd stays 0; SR reads UNDERRUN=1; the next SR read shows UNDERRUN=0.
REQ-040 Stereo build, push 0x12348000 -> left carries 0x8000, right carries 0x1234; mono build -> both channels carry 0x8000.
REQ-041 Byte access, read at addr 8, or addr 2 -> fault=1, resp=0, registers unchanged.

Source files
------------

// File: rtl/audplay_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audplay_controller: bus-mapped 16-deep sample FIFO feeding a serial audio  |
// | transmitter (sck/ws/sd). Define AUDPLAY_STEREO_EN for separate L/R words.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module audplay_controller #(
  parameter int PRIMARY_DIV = 26
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [3:0]                addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     rdata,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic                      resp,
  output logic                      fault,
  output logic                      sck,
  output logic                      ws,
  output logic                      sd
);

  localparam int c_DIV_W = (PRIMARY_DIV > 1) ? $clog2(PRIMARY_DIV) : 1;
`ifdef AUDPLAY_STEREO_EN
  localparam int c_WORD_W = 32;
`else
  localparam int c_WORD_W = 16;
`endif
  localparam logic [3:0] c_ADDR_DR = 4'd0;
  localparam logic [3:0] c_ADDR_SR = 4'd4;
  localparam logic [3:0] c_ADDR_CR = 4'd8;

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

  state_t               r_state, w_state_nxt;
  logic [5:0]           r_count, w_count_nxt;
  logic [c_DIV_W-1:0]   r_div;
  logic                 r_en, r_underrun, r_resp;
  logic [`BUS_WIDTH-1:0] r_rdata;
  logic [15:0]          r_frames;
  logic [c_WORD_W-1:0]  r_mem [16];
  logic [3:0]           r_wr_ptr, r_rd_ptr;
  logic [4:0]           r_level;
  logic [c_WORD_W-1:0]  r_word;

  logic w_full, w_empty, w_invalid, w_valid, w_push, w_cr_wr, w_sr_rd;
  logic w_flush, w_tick, w_pop, w_pop_data;
  logic [31:0] w_sr;
  logic [4:0]  w_b;
  logic [3:0]  w_idx;
  logic [15:0] w_left, w_right, w_chan;
  logic        w_unused_wdata;

  assign w_full  = (r_level == 5'd16);
  assign w_empty = (r_level == 5'd0);

  // Only aligned word accesses to DR (write), SR (read) and CR (write) are legal.
  assign w_invalid = (addr[1:0] != 2'd0) || (acc != `BUS_ACC_4B) || (addr > c_ADDR_CR)
                  || (w_rb && addr == c_ADDR_SR)
                  || (!w_rb && addr != c_ADDR_SR)
                  || (w_rb && addr == c_ADDR_DR && w_full);
  assign w_valid = req && !w_invalid;
  assign fault   = req && w_invalid;
  assign w_push  = w_valid && w_rb && (addr == c_ADDR_DR);
  assign w_cr_wr = w_valid && w_rb && (addr == c_ADDR_CR);
  assign w_sr_rd = w_valid && !w_rb;
  assign w_flush = w_cr_wr && wdata[30];
  assign w_unused_wdata = ^wdata;

  assign w_sr  = {r_underrun, w_full, w_empty, 8'd0, r_level, r_frames};
  assign resp  = r_resp;
  assign rdata = r_rdata;

  assign w_tick = (r_div == c_DIV_W'(PRIMARY_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn) r_div <= '0;
    else       r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_count <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pop       = 1'b0;
    if (!r_en) begin
      w_state_nxt = IDLE;
      w_count_nxt = 6'd0;
    end else if (w_tick) begin
      w_count_nxt = r_count + 6'd1;
      if (r_count == 6'd63) begin
        case (r_state)
          IDLE:    begin w_state_nxt = LOW;  w_pop = 1'b1; end
          LOW:     w_state_nxt = HIGH;
          default: begin w_state_nxt = LOW;  w_pop = 1'b1; end
        endcase
      end
    end
  end

  assign w_pop_data = w_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_resp     <= 1'b0;
      r_rdata    <= '0;
      r_en       <= 1'b0;
      r_underrun <= 1'b0;
      r_frames   <= 16'd0;
      r_word     <= '0;
      r_wr_ptr   <= 4'd0;
      r_rd_ptr   <= 4'd0;
      r_level    <= 5'd0;
    end else begin
      r_resp <= w_valid;
      if (w_sr_rd) r_rdata <= w_sr;
      if (w_cr_wr) r_en <= wdata[31];
      if (w_pop) begin
        r_frames <= r_frames + 16'd1;
        r_word   <= w_empty ? '0 : r_mem[r_rd_ptr];
      end
      // A same-cycle underrun beats the clear-on-read.
      if (w_pop && w_empty)  r_underrun <= 1'b1;
      else if (w_sr_rd)      r_underrun <= 1'b0;
      if (w_flush) begin
        r_wr_ptr <= 4'd0;
        r_rd_ptr <= 4'd0;
        r_level  <= 5'd0;
      end else begin
        if (w_push)     r_wr_ptr <= r_wr_ptr + 4'd1;
        if (w_pop_data) r_rd_ptr <= r_rd_ptr + 4'd1;
        r_level <= r_level + {4'd0, w_push} - {4'd0, w_pop_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata[c_WORD_W-1:0];
  end

  assign w_left = r_word[15:0];
`ifdef AUDPLAY_STEREO_EN
  assign w_right = r_word[31:16];
`else
  assign w_right = r_word[15:0];
`endif
  assign w_chan = (r_state == HIGH) ? w_right : w_left;

  // Bit slot b carries channel bit 16-b, so data starts one slot after ws changes.
  assign w_b   = r_count[5:1];
  assign w_idx = 4'(5'd16 - w_b);
  assign sck   = (r_state == IDLE) || r_count[0];
  assign ws    = (r_state == IDLE) || (r_state == HIGH);
  assign sd    = (r_state != IDLE) && (w_b != 5'd0) && (w_b <= 5'd16) && w_chan[w_idx];

endmodule

`default_nettype wire

// File: tb/tb_audplay_controller.sv
`default_nettype none
// Randomized bench for audplay_controller: scoreboard of bus responses plus a
// serial receiver comparing each transmitted frame with a queue-based FIFO model.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_audplay_controller;
  localparam int DIV = 4;

  logic clk, rstn, w_rb, req, resp, fault, sck, ws, sd;
  logic [3:0] addr;
  logic [`BUS_ACC_WIDTH-1:0] acc;
  logic [`BUS_WIDTH-1:0] wdata, rdata;

  audplay_controller #(.PRIMARY_DIV(DIV)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .w_rb(w_rb), .acc(acc),
    .rdata(rdata), .wdata(wdata), .req(req), .resp(resp), .fault(fault),
    .sck(sck), .ws(ws), .sd(sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic is_rd; logic [31:0] val;} exp_t;
  exp_t        sb_q[$];
  logic [31:0] m_q[$];
  logic [31:0] frame_q[$];
  bit          m_underrun, m_en;
  logic [15:0] m_frames;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_invalid(logic [3:0] a, logic wr, logic [1:0] ac, int lvl);
    if (a[1:0] != 2'd0 || ac != `BUS_ACC_4B || a > 4'd8) return 1'b1;
    case (a)
      4'd0:    return !wr || lvl >= 16;
      4'd4:    return wr;
      default: return !wr;
    endcase
  endfunction

  function automatic logic [31:0] sr_value();
    int lvl = m_q.size();
    return {m_underrun, lvl == 16, lvl == 0, 8'd0, 5'(lvl), m_frames};
  endfunction

  function automatic logic [15:0] right_of(logic [31:0] w);
`ifdef AUDPLAY_STEREO_EN
    return w[31:16];
`else
    return w[15:0];
`endif
  endfunction

  // Reference model: updates after each edge from the bus inputs seen at that edge.
  initial begin : model
    logic s_req, s_wr;
    logic [3:0] s_a;
    logic [1:0] s_acc;
    logic [31:0] s_d;
    bit valid, prev_ws, watch_idle, watch_low, low_done, pop_empty;
    int unsigned en_cyc, low_cyc, n;
    prev_ws = 1; watch_idle = 0; watch_low = 0; low_done = 0; en_cyc = 0; low_cyc = 0;
    forever begin
      @(posedge clk);
      s_req = req; s_wr = w_rb; s_a = addr; s_acc = acc; s_d = wdata;
      if (!rstn) begin
        m_q.delete(); frame_q.delete(); sb_q.delete();
        m_underrun = 0; m_en = 0; m_frames = 0;
        #1 prev_ws = ws;
        continue;
      end
      valid = s_req && !is_invalid(s_a, s_wr, s_acc, m_q.size());
      if (valid) sb_q.push_back('{is_rd: !s_wr, val: sr_value()});
      #1;
      pop_empty = 0;
      if (prev_ws && !ws) begin
        m_frames++;
        if (m_q.size() == 0) begin pop_empty = 1; frame_q.push_back(32'd0); end
        else frame_q.push_back(m_q.pop_front());
        if (watch_idle) begin
          n = cyc - en_cyc;
          n_tests++;
          if (n < 63*DIV+1 || n > 64*DIV) begin
            n_fail++;
            $display("FAIL idle_len: got %0d cycles, required %0d..%0d", n, 63*DIV+1, 64*DIV);
          end
          watch_idle = 0;
          if (!low_done) begin watch_low = 1; low_cyc = cyc; end
        end
      end
      if (!prev_ws && ws && watch_low) begin
        check("low_len", cyc - low_cyc, 64*DIV);
        watch_low = 0; low_done = 1;
      end
      if (valid && !s_wr) m_underrun = 0;
      if (pop_empty) m_underrun = 1;
      if (valid && s_wr && s_a == 4'd8) begin
        if (s_d[31] && !m_en) begin watch_idle = 1; en_cyc = cyc; end
        if (!s_d[31]) begin watch_idle = 0; watch_low = 0; end
        m_en = s_d[31];
        if (s_d[30]) m_q.delete();
      end else if (valid && s_wr && s_a == 4'd0) begin
        m_q.push_back(s_d);
      end
      prev_ws = ws;
    end
  end

  // Bus monitor: every resp must match the oldest outstanding expectation.
  initial begin : sb_mon
    exp_t e;
    bit exp_r;
    forever begin
      @(posedge clk); #1;
      if (!rstn) continue;
      exp_r = (sb_q.size() != 0);
      if (resp || exp_r) check("resp", resp, exp_r);
      if (exp_r) begin
        e = sb_q.pop_front();
        if (e.is_rd) check("sr_rdata", rdata, e.val);
      end
    end
  end

  // Serial receiver: 32 sck rising edges per channel, data in slots 1..16.
  initial begin : ser_mon
    logic p_sck, p_ws;
    logic [15:0] sh, left;
    logic [31:0] w;
    int k;
    bit left_ok, bad, lbad;
    p_sck = 1; p_ws = 1; k = 0; sh = 0; left = 0; left_ok = 0; bad = 0; lbad = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin p_sck = 1; p_ws = 1; k = 0; left_ok = 0; continue; end
      if (ws != p_ws) begin
        k = 0; sh = 0; bad = 0;
        if (!ws) left_ok = 0;
      end
      if (sck && !p_sck) begin
        if (k >= 1 && k <= 16) sh = {sh[14:0], sd};
        else if (sd) bad = 1;
        k++;
        if (k == 32) begin
          if (!ws) begin left = sh; lbad = bad; left_ok = 1; end
          else if (left_ok) begin
            left_ok = 0;
            if (frame_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL frame: got a frame, expected none");
            end else begin
              w = frame_q.pop_front();
              check("left_ch", left, w[15:0]);
              check("right_ch", sh, right_of(w));
              check("pad_bits", bad | lbad, 0);
            end
          end
        end
      end
      p_sck = sck; p_ws = ws;
    end
  end

  task automatic bus(input logic wr, input logic [3:0] a, input logic [1:0] ac, input logic [31:0] d);
    @(posedge clk); #2;
    req = 1; w_rb = wr; addr = a; acc = ac; wdata = d;
    #1 check("fault", fault, is_invalid(a, wr, ac, m_q.size()));
    @(posedge clk); #2;
    req = 0;
  endtask

  initial begin : stim
    logic [3:0] ra;
    logic [1:0] rac;
    logic rwr;
    int r;
    rstn = 0; req = 0; w_rb = 0; addr = 0; acc = `BUS_ACC_4B; wdata = 0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_sck", sck, 1);
    check("rst_ws", ws, 1);
    check("rst_sd", sd, 0);
    check("rst_resp", resp, 0);
    check("rst_rdata", rdata, 0);
    req = 1; addr = 4'd2;
    #1 check("rst_fault", fault, 1);
    req = 0; addr = 0;
    @(posedge clk); #2 rstn = 1;

    bus(0, 4'd4, `BUS_ACC_4B, 0);
    bus(0, 4'd8, `BUS_ACC_4B, 0);
    bus(1, 4'd2, `BUS_ACC_4B, 32'h80000000);
    bus(0, 4'd4, 2'd0, 0);
    bus(0, 4'd12, `BUS_ACC_4B, 0);
    bus(1, 4'd4, `BUS_ACC_4B, 0);
    bus(0, 4'd0, `BUS_ACC_4B, 0);
    for (int i = 0; i < 17; i++) bus(1, 4'd0, `BUS_ACC_4B, $urandom);
    bus(0, 4'd4, `BUS_ACC_4B, 0);
    bus(1, 4'd8, `BUS_ACC_4B, 32'h40000000);
    bus(0, 4'd4, `BUS_ACC_4B, 0);

    bus(1, 4'd0, `BUS_ACC_4B, 32'h12348000);
    bus(1, 4'd0, `BUS_ACC_4B, 32'h0000A5C3);
    for (int i = 0; i < 3; i++) bus(1, 4'd0, `BUS_ACC_4B, $urandom);
    bus(1, 4'd8, `BUS_ACC_4B, 32'h80000000);

    while (cyc < 7000) begin
      r = $urandom_range(0, 99);
      if (r < 3) bus(1, 4'd0, `BUS_ACC_4B, $urandom);
      else if (r < 20) bus(0, 4'd4, `BUS_ACC_4B, 0);
      else if (r < 26) begin
        ra = 4'($urandom); rwr = 1'($urandom); rac = 2'($urandom);
        if (!is_invalid(ra, rwr, rac, m_q.size())) rac = 2'd0;
        bus(rwr, ra, rac, 32'h80000000);
      end else if (r < 27) bus(1, 4'd8, `BUS_ACC_4B, 32'hC0000000);
      else repeat ($urandom_range(5, 40)) @(posedge clk);
    end

    // Drain with no pushes so underrun occurs and is cleared by reads.
    repeat (3) begin
      repeat (520) @(posedge clk);
      bus(0, 4'd4, `BUS_ACC_4B, 0);
      bus(0, 4'd4, `BUS_ACC_4B, 0);
    end

    bus(1, 4'd8, `BUS_ACC_4B, 32'h0);
    @(posedge clk); #1;
    check("dis_sck", sck, 1);
    check("dis_ws", ws, 1);
    check("dis_sd", sd, 0);
    bus(0, 4'd4, `BUS_ACC_4B, 0);
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
